// File: rtl/medidor_pwm.sv
// PWM receiver: measures high time (largura) and rise-to-rise period (periodo) of an
// asynchronous PWM input in clock cycles, flagging loss of signal and out-of-range widths.
module medidor_pwm #(
  parameter int unsigned N        = 32,
  parameter int unsigned TIMEOUT  = 2_000_000,
  parameter int unsigned LARG_MIN = 50_000,
  parameter int unsigned LARG_MAX = 100_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [N-1:0] largura,
  output logic [N-1:0] periodo,
  output logic         pronto,
  output logic         fora_faixa,
  output logic         sem_sinal
);

  localparam logic [N-1:0] TIMEOUT_N  = N'(TIMEOUT);
  localparam logic [N-1:0] LARG_MIN_N = N'(LARG_MIN);
  localparam logic [N-1:0] LARG_MAX_N = N'(LARG_MAX);
  localparam logic [N-1:0] UM         = N'(1);

  typedef enum logic [1:0] {
    INICIAL,
    MEDE_ALTO,
    MEDE_BAIXO
  } estado_t;

  estado_t      estado;
  logic         sinc;
  logic         pwm_s;
  logic         pwm_d;
  logic [2:0]   valido;
  logic         sobe;
  logic         desce;
  logic [N-1:0] cont;
  logic [N-1:0] larg_tmp;

  // valido gates edge detection until pwm_s/pwm_d hold real samples, so a line
  // that is already high when reset releases is not mistaken for a rise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc   <= 1'b0;
      pwm_s  <= 1'b0;
      pwm_d  <= 1'b0;
      valido <= 3'b000;
    end else begin
      sinc   <= pwm_in;
      pwm_s  <= sinc;
      pwm_d  <= pwm_s;
      valido <= {valido[1:0], 1'b1};
    end
  end

  assign sobe  = valido[2] & pwm_s & ~pwm_d;
  assign desce = valido[2] & ~pwm_s & pwm_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cont <= '0;
    end else if (sobe) begin
      cont <= UM;
    end else if (cont != TIMEOUT_N) begin
      cont <= cont + UM;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      larg_tmp   <= '0;
      largura    <= '0;
      periodo    <= '0;
      pronto     <= 1'b0;
      fora_faixa <= 1'b0;
      sem_sinal  <= 1'b0;
    end else begin
      pronto <= 1'b0;
      // A rise in the same cycle as the timeout takes priority.
      if (cont == TIMEOUT_N && !sobe) begin
        sem_sinal  <= 1'b1;
        largura    <= '0;
        periodo    <= '0;
        fora_faixa <= 1'b0;
        estado     <= INICIAL;
      end else begin
        case (estado)
          INICIAL: begin
            if (sobe) estado <= MEDE_ALTO;
          end
          MEDE_ALTO: begin
            if (desce) begin
              larg_tmp <= cont;
              estado   <= MEDE_BAIXO;
            end
          end
          MEDE_BAIXO: begin
            if (sobe) begin
              largura    <= larg_tmp;
              periodo    <= cont;
              fora_faixa <= (larg_tmp < LARG_MIN_N) || (larg_tmp > LARG_MAX_N);
              pronto     <= 1'b1;
              sem_sinal  <= 1'b0;
              estado     <= MEDE_ALTO;
            end
          end
          default: estado <= INICIAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_medidor_pwm.sv
// Directed bench for medidor_pwm (N=16, TIMEOUT=1000, LARG_MIN=20, LARG_MAX=40);
// each task drives one scenario and checks hand-computed results inline.
module tb_medidor_pwm;

  localparam int N        = 16;
  localparam int TIMEOUT  = 1000;
  localparam int LARG_MIN = 20;
  localparam int LARG_MAX = 40;

  logic         clock = 1'b0;
  logic         reset;
  logic         pwm_in;
  logic [N-1:0] largura;
  logic [N-1:0] periodo;
  logic         pronto;
  logic         fora_faixa;
  logic         sem_sinal;

  int checks     = 0;
  int errors     = 0;
  int pronto_cnt = 0;
  int wide_cnt   = 0;
  logic pronto_prev = 1'b0;

  medidor_pwm #(
    .N(N), .TIMEOUT(TIMEOUT), .LARG_MIN(LARG_MIN), .LARG_MAX(LARG_MAX)
  ) dut (
    .clock(clock), .reset(reset), .pwm_in(pwm_in),
    .largura(largura), .periodo(periodo), .pronto(pronto),
    .fora_faixa(fora_faixa), .sem_sinal(sem_sinal)
  );

  always #5 clock = ~clock;

  // Counts pronto pulses and any pulse that lasts longer than one cycle.
  always @(posedge clock) begin
    #2;
    if (pronto) begin
      pronto_cnt++;
      if (pronto_prev) wide_cnt++;
    end
    pronto_prev = pronto;
  end

  task automatic drive(input int hi, input int lo, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      repeat (hi) @(negedge clock);
      pwm_in = 1'b0;
      repeat (lo) @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (largura !== 0 || periodo !== 0 || pronto !== 0 || fora_faixa !== 0 || sem_sinal !== 0) begin
      errors++;
      $display("FAIL reset_outputs: got l=%0d p=%0d pr=%b ff=%b ss=%b required all 0",
               largura, periodo, pronto, fora_faixa, sem_sinal);
    end
    reset = 1'b1;
    repeat (TIMEOUT) @(posedge clock);
    #2;
    checks++;
    if (sem_sinal !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: sem_sinal=%b required 0 after %0d cycles", sem_sinal, TIMEOUT);
    end
    @(posedge clock);
    #2;
    checks++;
    if (sem_sinal !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge: sem_sinal=%b required 1 after %0d cycles", sem_sinal, TIMEOUT + 1);
    end
    checks++;
    if (pronto_cnt !== 0) begin
      errors++;
      $display("FAIL reset_no_pronto: pronto count=%0d required 0", pronto_cnt);
    end
    $display("test_reset: done, sem_sinal=%b", sem_sinal);
  endtask

  task automatic test_lock;
    int p0;
    p0 = pronto_cnt;
    drive(30, 70, 4);
    checks++;
    if (pronto_cnt - p0 !== 3) begin
      errors++;
      $display("FAIL lock_pronto_count: got %0d required 3", pronto_cnt - p0);
    end
    checks++;
    if (largura !== 16'd30 || periodo !== 16'd100 || fora_faixa !== 1'b0 || sem_sinal !== 1'b0) begin
      errors++;
      $display("FAIL lock_values: got l=%0d p=%0d ff=%b ss=%b required l=30 p=100 ff=0 ss=0",
               largura, periodo, fora_faixa, sem_sinal);
    end
    $display("test_lock: largura=%0d periodo=%0d", largura, periodo);
  endtask

  task automatic test_faixa;
    int his[5]    = '{10, 41, 40, 20, 19};
    logic exp_ff[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    int p0;
    for (int i = 0; i < 5; i++) begin
      p0 = pronto_cnt;
      drive(his[i], 100 - his[i], 3);
      checks++;
      if (pronto_cnt - p0 !== 3) begin
        errors++;
        $display("FAIL faixa_pronto_count[%0d]: got %0d required 3", his[i], pronto_cnt - p0);
      end
      checks++;
      if (largura !== 16'(his[i]) || periodo !== 16'd100 || fora_faixa !== exp_ff[i]) begin
        errors++;
        $display("FAIL faixa_values[%0d]: got l=%0d p=%0d ff=%b required l=%0d p=100 ff=%b",
                 his[i], largura, periodo, fora_faixa, his[i], exp_ff[i]);
      end
      $display("test_faixa: high=%0d largura=%0d fora_faixa=%b", his[i], largura, fora_faixa);
    end
  endtask

  task automatic test_partial;
    int p0;
    @(negedge clock);
    reset  = 1'b0;
    pwm_in = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    p0 = pronto_cnt;
    repeat (15) @(negedge clock);
    pwm_in = 1'b0;
    repeat (70) @(negedge clock);
    checks++;
    if (pronto_cnt !== p0) begin
      errors++;
      $display("FAIL partial_reported: pronto count=%0d required 0", pronto_cnt - p0);
    end
    drive(30, 70, 2);
    checks++;
    if (pronto_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL partial_first_pronto: count=%0d required 1", pronto_cnt - p0);
    end
    checks++;
    if (largura !== 16'd30 || periodo !== 16'd100 || fora_faixa !== 1'b0) begin
      errors++;
      $display("FAIL partial_values: got l=%0d p=%0d ff=%b required l=30 p=100 ff=0",
               largura, periodo, fora_faixa);
    end
    $display("test_partial: largura=%0d periodo=%0d", largura, periodo);
  endtask

  task automatic test_timeout;
    int p0;
    p0 = pronto_cnt;
    pwm_in = 1'b1;
    repeat (TIMEOUT + 2) @(posedge clock);
    #2;
    checks++;
    if (sem_sinal !== 1'b0 || largura !== 16'd30) begin
      errors++;
      $display("FAIL timeout_early_hold: got ss=%b l=%0d required ss=0 l=30", sem_sinal, largura);
    end
    @(posedge clock);
    #2;
    checks++;
    if (sem_sinal !== 1'b1 || largura !== 0 || periodo !== 0 || fora_faixa !== 0) begin
      errors++;
      $display("FAIL timeout_hold: got ss=%b l=%0d p=%0d ff=%b required ss=1 l=0 p=0 ff=0",
               sem_sinal, largura, periodo, fora_faixa);
    end
    checks++;
    if (pronto_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL timeout_pronto_count: got %0d required 1", pronto_cnt - p0);
    end
    p0 = pronto_cnt;
    @(negedge clock);
    pwm_in = 1'b0;
    repeat (70) @(negedge clock);
    drive(30, 70, 2);
    checks++;
    if (pronto_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL resume_pronto_count: got %0d required 1", pronto_cnt - p0);
    end
    checks++;
    if (largura !== 16'd30 || periodo !== 16'd100 || sem_sinal !== 1'b0) begin
      errors++;
      $display("FAIL resume_values: got l=%0d p=%0d ss=%b required l=30 p=100 ss=0",
               largura, periodo, sem_sinal);
    end
    $display("test_timeout: resumed largura=%0d sem_sinal=%b", largura, sem_sinal);
  endtask

  task automatic test_reset_mid_and_min;
    int p0;
    pwm_in = 1'b1;
    repeat (10) @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (largura !== 0 || periodo !== 0 || pronto !== 0 || sem_sinal !== 0) begin
      errors++;
      $display("FAIL async_reset: got l=%0d p=%0d pr=%b ss=%b required all 0",
               largura, periodo, pronto, sem_sinal);
    end
    pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    p0 = pronto_cnt;
    for (int k = 0; k < 40; k++) begin
      pwm_in = ~pwm_in;
      @(negedge clock);
    end
    checks++;
    if (largura !== 16'd1 || periodo !== 16'd2 || fora_faixa !== 1'b1) begin
      errors++;
      $display("FAIL min_pulse: got l=%0d p=%0d ff=%b required l=1 p=2 ff=1",
               largura, periodo, fora_faixa);
    end
    checks++;
    if (pronto_cnt - p0 < 10) begin
      errors++;
      $display("FAIL min_pulse_pronto: got %0d required at least 10", pronto_cnt - p0);
    end
    checks++;
    if (wide_cnt !== 0) begin
      errors++;
      $display("FAIL pronto_width: %0d multi-cycle pulses, required 0", wide_cnt);
    end
    $display("test_reset_mid_and_min: largura=%0d periodo=%0d", largura, periodo);
  endtask

  initial begin
    test_reset();
    test_lock();
    test_faixa();
    test_partial();
    test_timeout();
    test_reset_mid_and_min();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
